write_issuer: RTL and testbench
===============================

WRITE_ISSUER -- requirements
Module: write_issuer

Interface
REQ-001 Parameter MIN_READY, default 1, meaning consecutive ready cycles required before commit (legal 1..255).
REQ-002 Parameter TIMEOUT, default 64, meaning max WAIT cycles before abort (legal 2..65535).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  1  start-write request; sampled only in IDLE.
REQ-006 req_bit  input  1  data qualifier to issue; sampled with req.
REQ-007 ready  input  1  downstream readiness.
REQ-008 do_wr  output  1  write strobe (issue and commit cycles).
REQ-009 wr_valid  output  1  latched qualifier, held stable for the whole transaction.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse on successful commit.
REQ-012 timeout  output  1  one-cycle pulse on WAIT abort.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, COMMIT; encoding is free.
REQ-014 IDLE: req=1 -> capture req_bit into wr_valid register, go to ISSUE next cycle; req=0 -> stay.
REQ-015 ISSUE: do_wr=1 for exactly one cycle, wr_valid=captured value; unconditional transition to WAIT with ready-run counter and wait counter cleared.
REQ-016 WAIT: do_wr=0; ready=1 increments run counter, ready=0 clears it; wait counter increments every cycle.
REQ-017 WAIT: run counter reaching MIN_READY (including the current cycle's ready) -> COMMIT next cycle.
REQ-018 WAIT: wait counter reaching TIMEOUT without REQ-017 -> IDLE next cycle, timeout=1 in that transition cycle; REQ-017 takes priority if both occur in the same cycle.
REQ-019 COMMIT: do_wr = ready (combinational); ready=1 -> done=1 same cycle, IDLE next; ready=0 -> do_wr=0, back to WAIT with run counter cleared, wait counter retained.
REQ-020 wr_valid SHALL equal the captured value in ISSUE, WAIT and COMMIT, and 0 in IDLE.
REQ-021 Issue-to-commit latency SHALL be at least MIN_READY+1 cycles; ready at the ISSUE cycle is not counted.
REQ-022 req asserted while busy SHALL be ignored (no queuing); req in the cycle done pulses is ignored, and the next request is accepted from IDLE.
REQ-023 Counters SHALL saturate, never wrap; widths sized by $clog2 of their parameter plus 1.
REQ-024 done and timeout SHALL never be high simultaneously; neither is high outside the cycles given above.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, clear both counters and the captured qualifier, from any state including mid-transaction.
REQ-026 During and one cycle after reset: do_wr=0, wr_valid=0, busy=0, done=0, timeout=0.
REQ-027 A req sampled in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-028 MIN_READY=1, req=1 req_bit=1, ready held 1 -> do_wr at ISSUE (cycle 1), do_wr+done at cycle 3, wr_valid=1 in cycles 1-3.
REQ-029 MIN_READY=3, ready pattern 1,1,0,1,1,1 after ISSUE -> commit only after the third consecutive 1; do_wr=0 throughout WAIT.
REQ-030 TIMEOUT=8, ready held 0 -> timeout pulse 8 cycles after ISSUE, busy falls next cycle, no second do_wr.
REQ-031 ready drops exactly on the COMMIT cycle -> no do_wr, return to WAIT, commit after a fresh MIN_READY run, wr_valid unchanged.
REQ-032 rst pulsed during WAIT with req_bit=1 captured -> all outputs 0 next cycle; a following req with req_bit=0 yields wr_valid=0.
REQ-033 req held high continuously -> back-to-back transactions separated by one IDLE cycle; req pulses during busy produce no extra ISSUE.

Source files
------------

// File: rtl/write_issuer.sv
// Single-shot write issuer: latches a qualifier on request, strobes the write,
// waits for a run of ready cycles (bounded by a timeout), then commits.
module write_issuer #(
  parameter int unsigned MIN_READY = 1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic req_bit,
  input  logic ready,
  output logic do_wr,
  output logic wr_valid,
  output logic busy,
  output logic done,
  output logic timeout
);

  localparam int unsigned RUN_W  = $clog2(MIN_READY) + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;

  localparam logic [RUN_W-1:0]  RUN_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [RUN_W-1:0]  RUN_TGT  = RUN_W'(MIN_READY);
  localparam logic [WAIT_W-1:0] WAIT_TGT = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               cap_q, cap_d;

  logic [RUN_W-1:0]   run_inc;
  logic [WAIT_W-1:0]  wait_inc;

  // Saturating increments; counters never wrap.
  assign run_inc  = (run_q == RUN_MAX)   ? run_q  : run_q + RUN_W'(1);
  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      wait_q  <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      wait_q  <= wait_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    wait_d   = wait_q;
    cap_d    = cap_q;
    do_wr    = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    busy     = (state_q != S_IDLE);
    wr_valid = (state_q != S_IDLE) ? cap_q : 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap_d   = req_bit;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        do_wr   = 1'b1;
        run_d   = '0;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        run_d  = ready ? run_inc : '0;
        wait_d = wait_inc;
        // A completed ready run wins over a coincident timeout.
        if (ready && (run_inc >= RUN_TGT)) begin
          state_d = S_COMMIT;
        end else if (wait_inc >= WAIT_TGT) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (ready) begin
          do_wr   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          run_d   = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet while reset is asserted.
    if (rst) begin
      do_wr    = 1'b0;
      done     = 1'b0;
      timeout  = 1'b0;
      busy     = 1'b0;
      wr_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_write_issuer.sv
// Scoreboard bench: two issuers (MIN_READY=1 and MIN_READY=3, both TIMEOUT=8)
// driven with directed cycle vectors; a monitor compares every cycle's outputs.
module tb_write_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_bit_a = 1'b0, ready_a = 1'b0;
  logic req_b = 1'b0, req_bit_b = 1'b0, ready_b = 1'b0;
  logic do_wr_a, wr_valid_a, busy_a, done_a, timeout_a;
  logic do_wr_b, wr_valid_b, busy_b, done_b, timeout_b;

  always #5 clk = ~clk;

  write_issuer #(.MIN_READY(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_bit(req_bit_a), .ready(ready_a),
    .do_wr(do_wr_a), .wr_valid(wr_valid_a), .busy(busy_a), .done(done_a),
    .timeout(timeout_a)
  );

  write_issuer #(.MIN_READY(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_bit(req_bit_b), .ready(ready_b),
    .do_wr(do_wr_b), .wr_valid(wr_valid_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b)
  );

  // Output vector order: {do_wr, wr_valid, busy, done, timeout}
  typedef struct packed {
    logic [31:0] idx;
    logic [4:0]  exp;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int unsigned step_idx = 0;
  int unsigned total = 0;
  int unsigned passed = 0;

  localparam logic SA = 1'b0;
  localparam logic SB = 1'b1;

  // One cycle: drive the selected DUT, idle the other, queue expected outputs.
  task automatic step(input logic sel, input logic r, input logic q,
                      input logic b, input logic y, input logic [4:0] e);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst = r;
    req_a = (sel == SA) ? q : 1'b0;
    req_bit_a = (sel == SA) ? b : 1'b0;
    ready_a = (sel == SA) ? y : 1'b0;
    req_b = (sel == SB) ? q : 1'b0;
    req_bit_b = (sel == SB) ? b : 1'b0;
    ready_b = (sel == SB) ? y : 1'b0;
    ea.idx = step_idx;
    eb.idx = step_idx;
    ea.exp = (sel == SA) ? e : 5'b00000;
    eb.exp = (sel == SB) ? e : 5'b00000;
    qa.push_back(ea);
    qb.push_back(eb);
    step_idx++;
  endtask

  always @(negedge clk) begin
    exp_t ex;
    logic [4:0] got;
    if (qa.size() > 0) begin
      ex = qa.pop_front();
      got = {do_wr_a, wr_valid_a, busy_a, done_a, timeout_a};
      total++;
      if (got === ex.exp) passed++;
      else $display("FAIL dut_a step %0d outputs got %b want %b", ex.idx, got, ex.exp);
    end
    if (qb.size() > 0) begin
      ex = qb.pop_front();
      got = {do_wr_b, wr_valid_b, busy_b, done_b, timeout_b};
      total++;
      if (got === ex.exp) passed++;
      else $display("FAIL dut_b step %0d outputs got %b want %b", ex.idx, got, ex.exp);
    end
  end

  initial begin
    // Reset with a simultaneous request that must be dropped.
    step(SA, 1, 1, 1, 1, 5'b00000);
    step(SA, 0, 0, 0, 0, 5'b00000);
    step(SA, 0, 0, 0, 0, 5'b00000);

    // MIN_READY=1, ready held high.
    step(SA, 0, 1, 1, 1, 5'b00000);
    step(SA, 0, 0, 0, 1, 5'b11100);
    step(SA, 0, 0, 0, 1, 5'b01100);
    step(SA, 0, 0, 0, 1, 5'b11110);
    step(SA, 0, 0, 0, 1, 5'b00000);

    // MIN_READY=3, ready 1,1,0,1,1,1 after ISSUE.
    step(SB, 0, 1, 1, 0, 5'b00000);
    step(SB, 0, 0, 0, 1, 5'b11100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b11110);
    step(SB, 0, 0, 0, 0, 5'b00000);

    // Timeout with ready low; stray requests while busy are ignored.
    step(SB, 0, 1, 1, 0, 5'b00000);
    step(SB, 0, 0, 0, 0, 5'b11100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 1, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 1, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01101);
    step(SB, 0, 0, 0, 0, 5'b00000);
    step(SB, 0, 0, 0, 0, 5'b00000);

    // Ready drops on COMMIT: back to WAIT, fresh run of three needed.
    step(SB, 0, 1, 1, 0, 5'b00000);
    step(SB, 0, 0, 0, 1, 5'b11100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b11110);
    step(SB, 0, 0, 0, 0, 5'b00000);

    // Run completes on the timeout cycle (commit wins); retained wait count
    // then times out on the first WAIT cycle after a failed COMMIT.
    step(SB, 0, 1, 1, 0, 5'b00000);
    step(SB, 0, 0, 0, 0, 5'b11100);
    for (int i = 0; i < 5; i++) step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 1, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 0, 0, 0, 0, 5'b01101);
    step(SB, 0, 0, 0, 0, 5'b00000);

    // Reset mid-WAIT, then a new request with req_bit=0.
    step(SB, 0, 1, 1, 0, 5'b00000);
    step(SB, 0, 0, 0, 0, 5'b11100);
    step(SB, 0, 0, 0, 0, 5'b01100);
    step(SB, 1, 0, 0, 0, 5'b00000);
    step(SB, 0, 1, 0, 0, 5'b00000);
    step(SB, 0, 0, 0, 0, 5'b10100);
    step(SB, 0, 0, 0, 0, 5'b00100);
    step(SB, 1, 0, 0, 0, 5'b00000);
    step(SB, 0, 0, 0, 0, 5'b00000);

    // req held high: back-to-back transactions with one IDLE cycle between.
    step(SA, 0, 1, 1, 1, 5'b00000);
    step(SA, 0, 1, 0, 1, 5'b11100);
    step(SA, 0, 1, 0, 1, 5'b01100);
    step(SA, 0, 1, 0, 1, 5'b11110);
    step(SA, 0, 1, 0, 1, 5'b00000);
    step(SA, 0, 1, 1, 1, 5'b10100);
    step(SA, 0, 0, 1, 1, 5'b00100);
    step(SA, 0, 0, 0, 1, 5'b10110);
    step(SA, 0, 0, 0, 0, 5'b00000);
    step(SA, 0, 0, 0, 0, 5'b00000);

    for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      total++;
      $display("FAIL drain queues left a=%0d b=%0d want 0", qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
